// File: rtl/vga_sprite_ctrl.sv
// vga_sprite_ctrl
// Sequencing controller for the picture-ROM datapath. Owns the bouncing
// sprite position, the ROM read enable and the ROM address. The sprite is
// drawn only for whole frames and moves once per frame, bouncing off the
// screen edges.
//
// Optional feature: define MOTION_DIV_EN to apply the position update only
// on every FRAME_DIV-th frame. Without it the sprite moves on every frame.
module vga_sprite_ctrl #(
    parameter int H_VALID = 640,
    parameter int V_VALID = 480,
    parameter int H_PIC   = 100,
    parameter int V_PIC   = 100,
    parameter int ADR_MAX = 9999
`ifdef MOTION_DIV_EN
    ,
    parameter int FRAME_DIV = 4
`endif
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [9:0]  pix_x,
    input  logic [9:0]  pix_y,
    input  logic        enable,
    input  logic        hold,
    input  logic [2:0]  step,
    output logic        rom_rd_en,
    output logic [13:0] rom_addr,
    output logic        pic_valid,
    output logic [9:0]  sprite_x,
    output logic [9:0]  sprite_y,
    output logic        frame_done
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_MOVE   = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [13:0]       rom_addr_reg, rom_addr_next;
    logic              pic_valid_reg;
    logic [1:0][9:0]   pos_reg, pos_next;       // index 0 = x, 1 = y
    logic [1:0]        dir_neg_reg, dir_neg_next;
    logic              frame_end;
    logic              in_x, in_y;
    logic              div_hit;
    logic              motion_apply;
    logic signed [10:0] step_s;

    // Last active pixel of the frame.
    assign frame_end = (pix_x == 10'(H_VALID - 1)) && (pix_y == 10'(V_VALID - 1));

    // Sprite window, evaluated one bit wider so sprite_x + H_PIC never wraps.
    assign in_x = ({1'b0, pix_x} >= {1'b0, pos_reg[0]}) &&
                  ({1'b0, pix_x} <  ({1'b0, pos_reg[0]} + 11'(H_PIC)));
    assign in_y = ({1'b0, pix_y} >= {1'b0, pos_reg[1]}) &&
                  ({1'b0, pix_y} <  ({1'b0, pos_reg[1]} + 11'(V_PIC)));

    assign rom_rd_en  = (state_reg == ST_ACTIVE) && in_x && in_y;
    assign frame_done = (state_reg == ST_MOVE);
    assign rom_addr   = rom_addr_reg;
    assign pic_valid  = pic_valid_reg;
    assign sprite_x   = pos_reg[0];
    assign sprite_y   = pos_reg[1];
    assign step_s     = signed'({8'd0, step});

    // Next-state logic: dropping enable hides the sprite at once, showing it
    // again waits for a frame boundary so no partial sprite is drawn.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (frame_end && enable) begin
                    state_next = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (!enable) begin
                    state_next = ST_IDLE;
                end else if (frame_end) begin
                    state_next = ST_MOVE;
                end
            end
            ST_MOVE: begin
                state_next = enable ? ST_ACTIVE : ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // ROM address walks the sprite raster; outside ACTIVE it is parked at 0
    // so every frame starts from the first sprite pixel.
    always_comb begin
        rom_addr_next = rom_addr_reg;
        if (state_reg != ST_ACTIVE) begin
            rom_addr_next = '0;
        end else if (rom_rd_en) begin
            rom_addr_next = (rom_addr_reg == 14'(ADR_MAX)) ? '0 : rom_addr_reg + 14'd1;
        end
    end

`ifdef MOTION_DIV_EN
    localparam int DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

    logic [DIV_W-1:0] div_cnt_reg, div_cnt_next;

    // Frame counter advances once per MOVE and restarts whenever hidden.
    always_comb begin
        div_cnt_next = div_cnt_reg;
        if (state_reg == ST_IDLE) begin
            div_cnt_next = '0;
        end else if (state_reg == ST_MOVE) begin
            div_cnt_next = (div_cnt_reg == DIV_W'(FRAME_DIV - 1)) ? '0 : div_cnt_reg + 1'b1;
        end
    end

    // Frame counter register.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            div_cnt_reg <= '0;
        end else begin
            div_cnt_reg <= div_cnt_next;
        end
    end

    assign div_hit = (div_cnt_reg == DIV_W'(FRAME_DIV - 1));
`else
    assign div_hit = 1'b1;
`endif

    // A zero step or hold leaves both position and direction untouched.
    assign motion_apply = (state_reg == ST_MOVE) && !hold && (step != 3'd0) && div_hit;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_axis
            localparam logic signed [10:0] AXIS_MAX =
                (gi == 0) ? 11'(H_VALID - H_PIC) : 11'(V_VALID - V_PIC);

            logic signed [10:0] pos_s;
            logic signed [10:0] cand;
            logic [9:0]         pos_new;
            logic               dir_new;

            // Per-axis bounce: clamp at the edge and reverse in the same update.
            always_comb begin
                pos_s   = signed'({1'b0, pos_reg[gi]});
                cand    = dir_neg_reg[gi] ? (pos_s - step_s) : (pos_s + step_s);
                pos_new = pos_reg[gi];
                dir_new = dir_neg_reg[gi];
                if (motion_apply) begin
                    if (!dir_neg_reg[gi]) begin
                        if (cand >= AXIS_MAX) begin
                            pos_new = 10'(AXIS_MAX);
                            dir_new = 1'b1;
                        end else begin
                            pos_new = cand[9:0];
                        end
                    end else begin
                        if (cand <= 11'sd0) begin
                            pos_new = '0;
                            dir_new = 1'b0;
                        end else begin
                            pos_new = cand[9:0];
                        end
                    end
                end
            end

            assign pos_next[gi]     = pos_new;
            assign dir_neg_next[gi] = dir_new;
        end
    endgenerate

    // State, address, pipeline and position registers.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_reg     <= ST_IDLE;
            rom_addr_reg  <= '0;
            pic_valid_reg <= 1'b0;
            pos_reg       <= '0;
            dir_neg_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            rom_addr_reg  <= rom_addr_next;
            pic_valid_reg <= rom_rd_en;
            pos_reg       <= pos_next;
            dir_neg_reg   <= dir_neg_next;
        end
    end

endmodule

// File: tb/tb_vga_sprite_ctrl.sv
// Bench for vga_sprite_ctrl: randomized pixel coordinates against a
// behavioural model, plus literal checks on sprite positions and counts.
module tb_vga_sprite_ctrl;

    localparam int HV   = 640;
    localparam int VV   = 480;
    localparam int HP   = 100;
    localparam int VP   = 100;
    localparam int MAXX = HV - HP;
    localparam int MAXY = VV - VP;
`ifdef MOTION_DIV_EN
    localparam int FDIV = 4;
`endif

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic [9:0]  pix_x   = '0;
    logic [9:0]  pix_y   = '0;
    logic        enable  = 1'b0;
    logic        hold    = 1'b0;
    logic [2:0]  step    = 3'd1;
    logic        rom_rd_en;
    logic [13:0] rom_addr;
    logic        pic_valid;
    logic [9:0]  sprite_x;
    logic [9:0]  sprite_y;
    logic        frame_done;

    int n_checks = 0;
    int n_fail   = 0;
    int rd_count = 0;
    int fd_count = 0;

    vga_sprite_ctrl dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .enable    (enable),
        .hold      (hold),
        .step      (step),
        .rom_rd_en (rom_rd_en),
        .rom_addr  (rom_addr),
        .pic_valid (pic_valid),
        .sprite_x  (sprite_x),
        .sprite_y  (sprite_y),
        .frame_done(frame_done)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit in_spr(input int px, input int py, input int sx, input int sy);
        return (px >= sx) && (px < sx + HP) && (py >= sy) && (py < sy + VP);
    endfunction

    function automatic void axis_step(input int pos, input int dir, input int st, input int maxv,
                                      output int npos, output int ndir);
        int nxt;
        nxt  = pos + dir * st;
        npos = nxt;
        ndir = dir;
        if (dir > 0 && nxt >= maxv) begin
            npos = maxv;
            ndir = -1;
        end else if (dir < 0 && nxt <= 0) begin
            npos = 0;
            ndir = 1;
        end
    endfunction

    // ---------------- behavioural model ----------------
    bit m_shown = 0;   // sprite visible in this frame
    bit m_move  = 0;   // the single cycle after a drawn frame
    int m_x = 0, m_y = 0, m_dx = 1, m_dy = 1;
    int m_addr = 0;
    bit m_pv = 0;
    int m_frm = 0;

    always @(posedge sys_clk or posedge sys_rst) begin : model_upd
        bit rd, fe, upd;
        int nx, ndx, ny, ndy;
        if (sys_rst) begin
            m_shown <= 0; m_move <= 0;
            m_x <= 0; m_y <= 0; m_dx <= 1; m_dy <= 1;
            m_addr <= 0; m_pv <= 0; m_frm <= 0;
        end else begin
            rd = m_shown && in_spr(int'(pix_x), int'(pix_y), m_x, m_y);
            fe = (pix_x == 10'(HV - 1)) && (pix_y == 10'(VV - 1));
            m_pv <= rd;
            if (m_move) begin
                m_move  <= 0;
                m_shown <= enable;
                m_addr  <= 0;
                upd = !hold && (step != 0);
`ifdef MOTION_DIV_EN
                upd = upd && (m_frm == FDIV - 1);
                m_frm <= (m_frm + 1) % FDIV;
`endif
                if (upd) begin
                    axis_step(m_x, m_dx, int'(step), MAXX, nx, ndx);
                    axis_step(m_y, m_dy, int'(step), MAXY, ny, ndy);
                    m_x <= nx; m_dx <= ndx;
                    m_y <= ny; m_dy <= ndy;
                end
            end else if (m_shown) begin
                if (rd) m_addr <= (m_addr + 1) % (HP * VP);
                if (!enable) m_shown <= 0;
                else if (fe) begin
                    m_shown <= 0;
                    m_move  <= 1;
                end
            end else begin
                m_addr <= 0;
                m_frm  <= 0;
                if (fe && enable) m_shown <= 1;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge sys_clk) begin
        if (!sys_rst) begin
            check("rom_rd_en", rom_rd_en, m_shown && in_spr(int'(pix_x), int'(pix_y), m_x, m_y));
            check("rom_addr",  rom_addr,  m_addr);
            check("pic_valid", pic_valid, m_pv);
            check("sprite_x",  sprite_x,  m_x);
            check("sprite_y",  sprite_y,  m_y);
            check("frame_done", frame_done, m_move);
            if (rom_rd_en)  rd_count++;
            if (frame_done) fd_count++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int x, input int y);
        pix_x = 10'(x);
        pix_y = 10'(y);
        @(posedge sys_clk);
        #1;
    endtask

    task automatic short_frame(input int n);
        for (int i = 0; i < n; i++) begin
            int x, y;
            if ($urandom_range(1, 0) == 1) begin
                x = m_x + int'($urandom_range(HP - 1, 0));
                y = m_y + int'($urandom_range(VP - 1, 0));
            end else begin
                x = int'($urandom_range(HV - 1, 0));
                y = int'($urandom_range(VV - 1, 0));
            end
            if (x == HV - 1 && y == VV - 1) y = 0;
            cyc(x, y);
        end
        cyc(HV - 1, VV - 1);
        cyc(int'($urandom_range(HV - 1, 0)), int'($urandom_range(VV - 2, 0)));
    endtask

    task automatic scan_sprite(output int hits);
        int start, x0, y0;
        start = rd_count;
        x0 = (m_x > 0) ? m_x - 1 : 0;
        y0 = (m_y > 0) ? m_y - 1 : 0;
        for (int y = y0; y <= m_y + VP && y < VV; y++)
            for (int x = x0; x <= m_x + HP && x < HV; x++)
                if (!(x == HV - 1 && y == VV - 1)) cyc(x, y);
        hits = rd_count - start;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int hits, moves, fd0, px, py;

        repeat (3) @(posedge sys_clk);
        #1;
        check("reset rom_addr",   rom_addr, 0);
        check("reset pic_valid",  pic_valid, 0);
        check("reset frame_done", frame_done, 0);
        check("reset sprite_x",   sprite_x, 0);
        check("reset sprite_y",   sprite_y, 0);
        sys_rst = 1'b0;

        // Hidden until the first frame end, then drawn at (0,0).
        enable = 1'b1; step = 3'd1; hold = 1'b0;
        for (int i = 0; i < 20; i++) cyc(i * 3, i * 2);
        check("idle rd_en", rom_rd_en, 0);
        cyc(HV - 1, VV - 1);

        scan_sprite(hits);
        check("frame0 rd cycles", hits, HP * VP);
        cyc(HV - 1, VV - 1);
        check("frame0 frame_done", frame_done, 1);
        cyc(0, 0);
        moves = 1;
        check("after frame0 rom_addr", rom_addr, 0);
`ifndef MOTION_DIV_EN
        check("move1 x", sprite_x, 1);
        check("move1 y", sprite_y, 1);
`endif
        scan_sprite(hits);
        check("frame1 rd cycles", hits, HP * VP);
        cyc(HV - 1, VV - 1);
        cyc(5, 5);
        moves++;
`ifndef MOTION_DIV_EN
        check("move2 x", sprite_x, 2);
`endif

        // Unit steps until y bounces and x reaches 536.
        while (moves < 536) begin
            short_frame(int'($urandom_range(8, 2)));
            moves++;
`ifndef MOTION_DIV_EN
            if (moves == 380) begin
                check("bounce y top", sprite_y, 380);
                check("x at 380", sprite_x, 380);
            end
            if (moves == 381) check("after bounce y", sprite_y, 379);
`endif
        end
`ifndef MOTION_DIV_EN
        check("x at 536", sprite_x, 536);
        check("y at 536", sprite_y, 224);
`endif
        step = 3'd7;
        short_frame(5);
`ifndef MOTION_DIV_EN
        check("step7 x clamp", sprite_x, 540);
        check("step7 y", sprite_y, 217);
`endif
        short_frame(5);
`ifndef MOTION_DIV_EN
        check("step7 x back", sprite_x, 533);
        check("step7 y next", sprite_y, 210);
`endif

        // Hold for three frames: still drawn and pulsing, but frozen.
        px = m_x; py = m_y;
        hold = 1'b1;
        fd0 = fd_count;
        for (int f = 0; f < 3; f++) short_frame(10);
        check("hold frame_done pulses", fd_count - fd0, 3);
        check("hold x", sprite_x, px);
        check("hold y", sprite_y, py);
        hold = 1'b0; step = 3'd0;
        short_frame(6);
        check("step0 x", sprite_x, px);
        step = 3'd1;
        short_frame(6);

        // Drop enable while inside the sprite.
        px = m_x + 10; py = m_y + 50;
        cyc(px, py);
        check("pre-drop rd_en", rom_rd_en, 1);
        enable = 1'b0;
        cyc(px + 1, py);
        pix_x = 10'(px + 2);
        #1;
        check("drop rd_en next", rom_rd_en, 0);
        check("drop pic_valid", pic_valid, 1);
        @(posedge sys_clk); #1;
        check("drop pic_valid later", pic_valid, 0);
        check("drop rom_addr", rom_addr, 0);
        fd0 = fd_count;
        enable = 1'b1;
        pix_x = 10'(px + 3);
        #1;
        check("reenable mid-frame rd_en", rom_rd_en, 0);
        @(posedge sys_clk); #1;
        for (int i = 0; i < 10; i++) cyc(px + i, py + 1);
        cyc(HV - 1, VV - 1);
        cyc(0, 0);
        check("no frame_done from idle", fd_count - fd0, 0);
        short_frame(12);
        check("frame_done after full frame", fd_count - fd0, 1);

        // Randomized traffic.
        for (int f = 0; f < 150; f++) begin
            step = 3'($urandom_range(7, 0));
            hold = ($urandom_range(7, 0) == 0);
            if ($urandom_range(9, 0) == 0) begin
                cyc(m_x + 5, m_y + 5);
                enable = 1'b0;
                repeat (int'($urandom_range(4, 1))) cyc(m_x + 6, m_y + 6);
                enable = 1'b1;
            end
            short_frame(int'($urandom_range(20, 3)));
        end

        // Asynchronous reset in the middle of a drawn frame.
        enable = 1'b1; hold = 1'b0; step = 3'd3;
        short_frame(4);
        cyc(m_x + 20, m_y + 20);
        pix_x = 10'(m_x + 21);
        #2;
        sys_rst = 1'b1;
        #1;
        check("async rst rd_en", rom_rd_en, 0);
        check("async rst rom_addr", rom_addr, 0);
        check("async rst pic_valid", pic_valid, 0);
        check("async rst sprite_x", sprite_x, 0);
        check("async rst sprite_y", sprite_y, 0);
        check("async rst frame_done", frame_done, 0);
        repeat (2) @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        short_frame(5);
        short_frame(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
